// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a word over valid/ready, drives the baud divider's
// clear/enable and serialises start, data (LSB first), optional parity and stop bits.
module uart_tx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [DATA_BITS-1:0] DIN,
    input  logic                 DIN_VLD,
    output logic                 DIN_RDY,
    output logic                 UART_TXD,
    output logic                 BUSY,
    output logic                 FRAME_DONE,
    output logic                 DIV_CLEAR,
    output logic                 DIV_ENABLE,
    input  logic                 DIV_MARK
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_nxt;
    logic                 stop_cnt;
    logic                 stop_cnt_nxt;
    logic                 par;
    logic                 par_nxt;
    logic                 txd_nxt;
    logic                 done_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            UART_TXD   <= 1'b1;
            FRAME_DONE <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par        <= 1'b0;
        end else begin
            state      <= state_nxt;
            UART_TXD   <= txd_nxt;
            FRAME_DONE <= done_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            par        <= par_nxt;
        end
    end

    // The shift register is consumed from bit 0; each data mark shifts and emits the new bit 0.
    always_comb begin
        state_nxt    = state;
        txd_nxt      = UART_TXD;
        done_nxt     = 1'b0;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        par_nxt      = par;
        case (state)
            IDLE: begin
                if (DIN_VLD) begin
                    shreg_nxt = DIN;
                    par_nxt   = (PARITY_TYPE == 2) ? ~(^DIN) : ^DIN;
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (DIV_MARK) begin
                    txd_nxt   = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (DIV_MARK) begin
                    txd_nxt     = shreg[0];
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (DIV_MARK) begin
                    if (bit_cnt < 3'(DATA_BITS - 1)) begin
                        shreg_nxt   = {1'b0, shreg[DATA_BITS-1:1]};
                        txd_nxt     = shreg[1];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end else if (PARITY_TYPE != 0) begin
                        txd_nxt   = par;
                        state_nxt = PARITY;
                    end else begin
                        txd_nxt      = 1'b1;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = STOP;
                    end
                end
            end
            PARITY: begin
                if (DIV_MARK) begin
                    txd_nxt      = 1'b1;
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = STOP;
                end
            end
            STOP: begin
                if (DIV_MARK) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign DIN_RDY    = (state == IDLE);
    assign BUSY       = (state != IDLE);
    assign DIV_CLEAR  = (state == IDLE);
    assign DIV_ENABLE = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four instances (8N1, 8E1, 8O1, 5N2 with a modelled divider)
// checked symbol by symbol against hand-computed frames.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din8;
    logic [4:0] din5;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] txd;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] clr;
    logic [3:0] en;
    logic [1:0] mcnt;
    logic       mark4;
    logic [2:0] dcnt;
    logic       mark_div;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    // Free-running mark every 4 cycles for the first three instances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= '0;
        else        mcnt <= mcnt + 2'd1;
    end
    assign mark4 = (mcnt == 2'd3);

    // Divider model: counts 0..7 while enabled, held at 0 by clear, mark at count 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     dcnt <= '0;
        else if (clr[3]) dcnt <= '0;
        else if (en[3])  dcnt <= dcnt + 3'd1;
    end
    assign mark_div = en[3] && (dcnt == 3'd1);

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_TYPE(0), .STOP_BITS(1)) dut_n (
        .CLK(clk), .RST_N(rst_n), .DIN(din8), .DIN_VLD(vld[0]), .DIN_RDY(rdy[0]),
        .UART_TXD(txd[0]), .BUSY(busy[0]), .FRAME_DONE(done[0]), .DIV_CLEAR(clr[0]),
        .DIV_ENABLE(en[0]), .DIV_MARK(mark4));

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_TYPE(1), .STOP_BITS(1)) dut_e (
        .CLK(clk), .RST_N(rst_n), .DIN(din8), .DIN_VLD(vld[1]), .DIN_RDY(rdy[1]),
        .UART_TXD(txd[1]), .BUSY(busy[1]), .FRAME_DONE(done[1]), .DIV_CLEAR(clr[1]),
        .DIV_ENABLE(en[1]), .DIV_MARK(mark4));

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_TYPE(2), .STOP_BITS(1)) dut_o (
        .CLK(clk), .RST_N(rst_n), .DIN(din8), .DIN_VLD(vld[2]), .DIN_RDY(rdy[2]),
        .UART_TXD(txd[2]), .BUSY(busy[2]), .FRAME_DONE(done[2]), .DIV_CLEAR(clr[2]),
        .DIV_ENABLE(en[2]), .DIV_MARK(mark4));

    uart_tx_ctrl #(.DATA_BITS(5), .PARITY_TYPE(0), .STOP_BITS(2)) dut_5 (
        .CLK(clk), .RST_N(rst_n), .DIN(din5), .DIN_VLD(vld[3]), .DIN_RDY(rdy[3]),
        .UART_TXD(txd[3]), .BUSY(busy[3]), .FRAME_DONE(done[3]), .DIV_CLEAR(clr[3]),
        .DIV_ENABLE(en[3]), .DIV_MARK(mark_div));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for the start edge, then checks the first and last cycle of every symbol
    // (bit k of exp_bits is symbol k) and the FRAME_DONE pulse right after the last one.
    task automatic capture(input int s, input int p, input int n,
                           input logic [15:0] exp_bits, input string tag);
        int t = 0;
        int rdy_hi = 0;
        int done_early = 0;
        while (txd[s] !== 1'b0 && t < 3 * p) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start_edge"}, 32'(txd[s]), 32'd0);
        if (txd[s] !== 1'b0) return;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < p; j++) begin
                if (j == 0 || j == p - 1)
                    check($sformatf("%s_sym%0d_c%0d", tag, k, j), 32'(txd[s]), 32'(exp_bits[k]));
                rdy_hi     += int'(rdy[s]);
                done_early += int'(done[s]);
                @(negedge clk);
            end
        end
        check({tag, "_rdy_low"}, rdy_hi, 0);
        check({tag, "_done_early"}, done_early, 0);
        check({tag, "_done"}, 32'(done[s]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt_a;
        int cnt_b;
        int cnt_c;
        int t;
        rst_n = 1'b0;
        din8  = '0;
        din5  = '0;
        vld   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_txd",  32'(txd[0]),  32'd1);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_rdy",  32'(rdy[0]),  32'd1);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_clr",  32'(clr[0]),  32'd1);
        check("rst_en",   32'(en[0]),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, 0x55
        din8 = 8'h55; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        check("f55_accept", 32'(busy[0]), 32'd1);
        check("f55_txd_sync", 32'(txd[0]), 32'd1);
        capture(0, 4, 10, 16'h02AA, "f55");
        @(negedge clk);
        check("f55_done_1cyc", 32'(done[0]), 32'd0);
        check("f55_idle", 32'(busy[0]), 32'd0);

        // 8E1 / 8O1, 0xA3: parity 0 / 1
        din8 = 8'hA3; vld[1] = 1'b1; vld[2] = 1'b1;
        @(negedge clk);
        vld[1] = 1'b0; vld[2] = 1'b0;
        fork
            capture(1, 4, 11, 16'h0546, "fa3_even");
            capture(2, 4, 11, 16'h0746, "fa3_odd");
        join
        repeat (2) @(negedge clk);

        // Back-to-back with DIN_VLD held; DIN changes during the first frame
        din8 = 8'h0F; vld[0] = 1'b1;
        @(negedge clk);
        check("b2b_accept1", 32'(busy[0]), 32'd1);
        din8 = 8'hF0;
        capture(0, 4, 10, 16'h021E, "b2b1");
        check("b2b_rdy_at_done", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        check("b2b_accept2", 32'(busy[0]), 32'd1);
        check("b2b_line_high", 32'(txd[0]), 32'd1);
        vld[0] = 1'b0;
        capture(0, 4, 10, 16'h03E0, "b2b2");
        cnt_a = 0;
        repeat (20) begin
            @(negedge clk);
            cnt_a += int'(busy[0]);
        end
        check("b2b_no_third", cnt_a, 0);

        // Reset during data bit 3 (0x55 bit 3 is 0)
        din8 = 8'h55; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        t = 0;
        while (txd[0] !== 1'b0 && t < 12) begin
            @(negedge clk);
            t++;
        end
        repeat (18) @(negedge clk);
        check("mid_rst_pre", 32'(txd[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd_async", 32'(txd[0]), 32'd1);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy", 32'(rdy[0]), 32'd1);
        cnt_a = 0;
        cnt_b = 0;
        repeat (50) begin
            @(negedge clk);
            cnt_a += int'(done[0]);
            cnt_b += int'(busy[0]);
        end
        check("mid_rst_no_done", cnt_a, 0);
        check("mid_rst_stay_idle", cnt_b, 0);
        din8 = 8'h55; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        capture(0, 4, 10, 16'h02AA, "post_rst");
        @(negedge clk);

        // Marks while idle have no effect
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        repeat (24) begin
            @(negedge clk);
            cnt_a += int'(!txd[0]);
            cnt_b += int'(busy[0]);
            cnt_c += int'(!clr[0]);
        end
        check("idle_mark_txd", cnt_a, 0);
        check("idle_mark_busy", cnt_b, 0);
        check("idle_mark_clr", cnt_c, 0);

        // 5N2, 0x1B with the divider model, 8-cycle symbols
        din5 = 5'h1B; vld[3] = 1'b1;
        @(negedge clk);
        vld[3] = 1'b0;
        check("f5_accept", 32'(busy[3]), 32'd1);
        capture(3, 8, 8, 16'h00F6, "f5n2");
        @(negedge clk);
        check("f5_done_1cyc", 32'(done[3]), 32'd0);
        check("f5_idle", 32'(busy[3]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
